serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder. Each cycle, one full-adder slice (two half-adder stages and an OR on the carries) processes one bit pair, LSB first, with the carry held in a register between bits.
- Sits directly downstream of the half adder and consumes its SUM/CARRY outputs. It is the first multi-bit arithmetic block built on that cell.
- Start/done handshake. The result is held stable until the next accepted START.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
CLK    input   1      rising-edge clock
RST_N  input   1      asynchronous active-low reset
START  input   1      request to add A and B; sampled on CLK rising edge
A      input   WIDTH  operand A; captured only on the edge that accepts START
B      input   WIDTH  operand B; captured only on the edge that accepts START
BUSY   output  1      high while an addition is in progress (RUN state)
DONE   output  1      one-cycle pulse: SUM/CARRY have just been updated
SUM    output  WIDTH  registered result, low WIDTH bits of A+B
CARRY  output  1      registered carry-out of bit WIDTH-1

Behaviour:
- Reset (RST_N low, asynchronous):
  - State goes to IDLE.
  - BUSY=0, DONE=0, SUM=0, CARRY=0.
  - Internal operand shift registers, carry register and bit counter are cleared.
  - Reset asserted mid-RUN aborts the operation and no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at edge k: latch A and B into shift registers, clear the carry register, set counter to 0, go to RUN.
  - START=0: stay in IDLE.
- RUN (BUSY=1):
  - Each edge computes bit i from the LSBs of the operand shift registers and the carry register:
    - first half adder: p = a^b, g1 = a&b
    - second half adder: s = p^c, g2 = p&c
    - next carry = g1|g2
  - s shifts into the MSB of an internal result shift register (shift right). Both operand registers shift right by one. Counter increments.
  - On the edge where counter == WIDTH-1 (edge k+WIDTH):
    - the final bit is processed;
    - SUM is loaded with the completed result register, CARRY with the final carry;
    - go to FIN.
- FIN (1 cycle):
  - DONE=1, BUSY=0.
  - START=1 here is accepted exactly as in IDLE (back-to-back operation): go to RUN, latch the new operands.
  - Otherwise go to IDLE.
- START is ignored while in RUN. Operands may change freely after the accepting edge with no effect on the result in progress.
- SUM/CARRY change only on the completing edge. They hold their value through IDLE, FIN and any subsequent RUN until the next completion.
- Latency: START accepted at edge k means BUSY=1 during cycles k+1..k+WIDTH, and DONE=1 for the cycle following edge k+WIDTH.
- Throughput: one addition per WIDTH+1 cycles.
- Arithmetic: {CARRY,SUM} == A+B exactly (WIDTH+1-bit unsigned result). No signed interpretation.
- DONE never asserts without a preceding accepted START since the last reset.

Test Plan:
WIDTH=8 unless noted.
- Reset release, no START for 20 cycles -> BUSY=0, DONE=0, SUM=0x00, CARRY=0 throughout.
- A=0x01, B=0x01, START pulse -> BUSY high 8 cycles, then DONE for 1 cycle with SUM=0x02, CARRY=0.
- A=0xFF, B=0x01 -> SUM=0x00, CARRY=1 (full carry ripple).
- A=0xC8 (200), B=0x64 (100) -> SUM=0x2C, CARRY=1.
- A=0xA5, B=0x5A, then START re-asserted during FIN with A=0x0F, B=0x01:
  - first DONE: SUM=0xFF, CARRY=0;
  - second op starts without an IDLE cycle;
  - second DONE 9 cycles later: SUM=0x10, CARRY=0.
- Mid-operation disturbances:
  - START and changed A/B applied during RUN -> ignored; result still matches the originally latched operands.
  - RST_N pulsed low at cycle 4 of RUN -> outputs zero immediately, no DONE; a new START afterwards completes correctly.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder slice per clock, LSB first
// Ports: CLK/RST_N clock and async active-low reset; START with A/B requests an add,
// and A/B are captured on the accepting edge. BUSY is high while bits are being processed.
// DONE pulses for one cycle after SUM/CARRY load. SUM/CARRY hold {carry-out, low WIDTH bits} of A+B.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_p, w_g1, w_s, w_g2, w_c, w_accept, w_last;
  logic [WIDTH-1:0] w_cat;
  half_adder u_ha1 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_p), .o_c(w_g1));
  half_adder u_ha2 (.i_a(w_p),    .i_b(r_c),    .o_s(w_s), .o_c(w_g2));
  assign w_c      = w_g1 | w_g2;
  // new bit enters at the top; after the last bit w_cat is the full result
  assign w_cat    = {w_s, r_res};
  assign w_accept = START && (r_state != RUN);
  assign w_last   = r_cnt == LAST;
  always_comb begin
    w_next = (r_state == RUN) ? (w_last ? FIN : RUN) : (START ? RUN : IDLE);
    BUSY   = r_state == RUN;
    DONE   = r_state == FIN;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      SUM   <= '0;
      CARRY <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_cat[WIDTH-1:1];
      r_c   <= w_c;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        SUM   <= w_cat;
        CARRY <= w_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against a countdown model
module tb_serial_adder;
  localparam int W = 8;
  logic         CLK = 0, RST_N = 1, START = 0;
  logic [W-1:0] A = 0, B = 0;
  logic         BUSY, DONE, CARRY;
  logic [W-1:0] SUM;
  int n_cmp = 0, n_bad = 0;
  int           m_left = 0;
  logic         m_done = 0;
  logic [W:0]   m_res = 0, m_pend = 0;
  logic         chk_en = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  // model: an accepted request yields A+B after exactly W busy cycles, then one DONE cycle
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      m_left <= 0;
      m_done <= 0;
      m_res  <= 0;
    end else if (m_left == 0 && START) begin
      m_pend <= {1'b0, A} + {1'b0, B};
      m_left <= W;
      m_done <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_res  <= m_pend;
        m_done <= 1;
      end
    end else m_done <= 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK)
    if (chk_en) begin
      chk("cyc_busy", 32'(BUSY), 32'(m_left > 0));
      chk("cyc_done", 32'(DONE), 32'(m_done));
      chk("cyc_result", 32'({CARRY, SUM}), 32'(m_res));
    end

  // issues one add; optional START+new operands pulse injected on the third RUN cycle
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    int n = 0;
    logic [W:0] exp = {1'b0, a} + {1'b0, b};
    @(negedge CLK);
    START = 1; A = a; B = b;
    @(negedge CLK);
    START = 0; A = W'($urandom); B = W'($urandom);
    while (BUSY && n < 20) begin
      n++;
      START = disturb && n == 3;
      if (START) begin A = ~a; B = a; end
      @(negedge CLK);
    end
    START = 0;
    chk("busy_len", 32'(n), W);
    chk("done", 32'(DONE), 1);
    chk("op_result", 32'({CARRY, SUM}), 32'(exp));
  endtask

  initial begin
    #2 RST_N = 0;
    chk_en = 1;
    repeat (2) @(negedge CLK);
    RST_N = 1;
    repeat (20) @(negedge CLK);
    chk("idle_sum", 32'({CARRY, SUM}), 0);
    chk("idle_busy", 32'({BUSY, DONE}), 0);
    op(8'h01, 8'h01, 0);
    chk("lit_01_01", 32'({CARRY, SUM}), 9'h002);
    op(8'hFF, 8'h01, 0);
    chk("lit_ff_01", 32'({CARRY, SUM}), 9'h100);
    op(8'hC8, 8'h64, 0);
    chk("lit_c8_64", 32'({CARRY, SUM}), 9'h12C);
    // back-to-back: restart during FIN
    op(8'hA5, 8'h5A, 0);
    chk("lit_a5_5a", 32'({CARRY, SUM}), 9'h0FF);
    START = 1; A = 8'h0F; B = 8'h01;
    @(negedge CLK);
    START = 0;
    chk("b2b_busy", 32'({BUSY, DONE}), 2'b10);
    chk("b2b_hold", 32'({CARRY, SUM}), 9'h0FF);
    repeat (W) @(negedge CLK);
    chk("b2b_done", 32'(DONE), 1);
    chk("lit_0f_01", 32'({CARRY, SUM}), 9'h010);
    op(8'h3C, 8'hE1, 1);
    chk("lit_disturb", 32'({CARRY, SUM}), 9'h11D);
    // async reset in the middle of RUN
    @(negedge CLK);
    START = 1; A = 8'h33; B = 8'h44;
    @(negedge CLK);
    START = 0;
    repeat (3) @(negedge CLK);
    #1 RST_N = 0;
    #1 chk("rst_mid", 32'({BUSY, DONE, CARRY, SUM}), 0);
    @(negedge CLK);
    RST_N = 1;
    repeat (12) @(negedge CLK);
    chk("rst_no_done", 32'({BUSY, DONE}), 0);
    op(8'h7F, 8'h81, 0);
    chk("lit_7f_81", 32'({CARRY, SUM}), 9'h100);
    for (int i = 0; i < 40; i++) begin
      op(W'($urandom), W'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
